// File: rtl/request_encoder_32to5.sv
// Sticky 32-lane request latch with round-robin (or fixed-priority) encode to a 5-bit lane code.
// req_in -> code_valid in two edges; code_out held stable until code_ready, one idle bubble per code.
module request_encoder_32to5 #(
  parameter int N           = 32,
  parameter int IDX_W       = 5,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic             clr_all,
  input  logic             code_ready,
  output logic [IDX_W-1:0] code_out,
  output logic             code_valid,
  output logic [N-1:0]     pending,
  output logic [IDX_W:0]   pending_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] code_nxt;
  logic [N-1:0]     pend_nxt;
  logic [N-1:0]     accept_mask;
  logic [2*N-1:0]   pend_dbl;
  logic [N-1:0]     pend_rot;
  logic [IDX_W-1:0] sel_off;
  logic [IDX_W-1:0] sel;
  logic             accept;

  assign code_valid = (state == HOLD);
  assign accept     = code_valid & code_ready;

  // A fresh request on the accepted lane wins over the accept-clear.
  always_comb begin
    accept_mask = '0;
    if (accept) begin
      accept_mask[code_out] = 1'b1;
    end
    pend_nxt = clr_all ? '0 : (req_in | (pending & ~accept_mask));
  end

  // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    pend_dbl = {pending, pending};
    pend_rot = ROUND_ROBIN ? pend_dbl[ptr +: N] : pending;
    sel_off  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_rot[i]) begin
        sel_off = IDX_W'(i);
      end
    end
    sel = ROUND_ROBIN ? (ptr + sel_off) : sel_off;
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code_out;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (!clr_all && (pending != '0)) begin
          code_nxt  = sel;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Flush wins over a simultaneous accept and leaves the pointer alone.
        if (clr_all) begin
          state_nxt = IDLE;
        end else if (code_ready) begin
          state_nxt = IDLE;
          ptr_nxt   = code_out + IDX_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      code_out      <= '0;
      ptr           <= '0;
      pending       <= '0;
      pending_count <= '0;
    end else begin
      state         <= state_nxt;
      code_out      <= code_nxt;
      ptr           <= ptr_nxt;
      pending       <= pend_nxt;
      pending_count <= (IDX_W + 1)'($countones(pend_nxt));
    end
  end

endmodule

// File: tb/tb_request_encoder_32to5.sv
// Bench for request_encoder_32to5: round-robin and fixed-priority instances share stimulus
// and are compared against a lane-array model, plus directed scenarios.
module tb_request_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_in;
  logic        clr_all;
  logic        code_ready;

  logic [4:0]  rr_code, fp_code;
  logic        rr_valid, fp_valid;
  logic [31:0] rr_pend, fp_pend;
  logic [5:0]  rr_cnt, fp_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  request_encoder_32to5 #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr_all(clr_all), .code_ready(code_ready),
    .code_out(rr_code), .code_valid(rr_valid), .pending(rr_pend), .pending_count(rr_cnt)
  );

  request_encoder_32to5 #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr_all(clr_all), .code_ready(code_ready),
    .code_out(fp_code), .code_valid(fp_valid), .pending(fp_pend), .pending_count(fp_cnt)
  );

  // Reference: index 0 models round-robin, index 1 fixed priority.
  logic [31:0] m_pend [2];
  int          m_ptr  [2];
  bit          m_off  [2];
  int          m_code [2];

  always @(posedge clk) begin : model
    logic [31:0] nxt;
    bit          acc;
    bit          found;
    int          idx;
    for (int u = 0; u < 2; u++) begin
      acc = m_off[u] && code_ready;
      if (!rst_n) begin
        m_pend[u] = '0;
        m_ptr[u]  = 0;
        m_off[u]  = 1'b0;
        m_code[u] = 0;
      end else begin
        for (int i = 0; i < 32; i++)
          nxt[i] = !clr_all && (req_in[i] || (m_pend[u][i] && !(acc && m_code[u] == i)));
        if (m_off[u]) begin
          if (clr_all) m_off[u] = 1'b0;
          else if (acc) begin
            m_off[u] = 1'b0;
            m_ptr[u] = (m_code[u] + 1) % 32;
          end
        end else if (!clr_all && m_pend[u] != 0) begin
          found = 1'b0;
          for (int k = 0; k < 32; k++) begin
            idx = (u == 0) ? (m_ptr[u] + k) % 32 : k;
            if (!found && m_pend[u][idx]) begin
              found     = 1'b1;
              m_code[u] = idx;
            end
          end
          m_off[u] = 1'b1;
        end
        m_pend[u] = nxt;
      end
    end
  end

  function automatic logic [43:0] exp_of(int u);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[u][i]);
    return {m_off[u], 5'(m_code[u]), m_pend[u], 6'(c)};
  endfunction

  logic [87:0] got_all;
  assign got_all = {rr_valid, rr_code, rr_pend, rr_cnt, fp_valid, fp_code, fp_pend, fp_cnt};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_in = '0; clr_all = 1'b0; code_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = 32'hFFFF_FFFF; clr_all = 1'b0; code_ready = 1'b1;
    step(); step();
    n_chk++;
    if ({rr_valid, rr_code, rr_pend, rr_cnt} !== 44'd0) begin
      n_fail++; $display("FAIL reset_rr: got %h want 0", {rr_valid, rr_code, rr_pend, rr_cnt});
    end
    n_chk++;
    if ({fp_valid, fp_code, fp_pend, fp_cnt} !== 44'd0) begin
      n_fail++; $display("FAIL reset_fp: got %h want 0", {fp_valid, fp_code, fp_pend, fp_cnt});
    end
    rst_n = 1'b1; req_in = '0; code_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_in = 32'h1; code_ready = 1'b1;
    step();
    req_in = '0;
    n_chk++;
    if ({rr_valid, rr_pend} !== {1'b0, 32'h1}) begin
      n_fail++; $display("FAIL single_edge1: got v=%b p=%h want v=0 p=1", rr_valid, rr_pend);
    end
    step();
    n_chk++;
    if ({rr_valid, rr_code} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL single_offer: got v=%b c=%0d want v=1 c=0", rr_valid, rr_code);
    end
    step();
    n_chk++;
    if ({rr_valid, rr_pend, rr_cnt} !== {1'b0, 32'h0, 6'd0}) begin
      n_fail++; $display("FAIL single_accept: got v=%b p=%h n=%0d want 0/0/0", rr_valid, rr_pend, rr_cnt);
    end
    n_chk++;
    if (got_all !== {exp_of(0), exp_of(1)}) begin
      n_fail++; $display("FAIL single_model: got %h want %h", got_all, {exp_of(0), exp_of(1)});
    end
    code_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int codes [2];
    int times [2];
    int got_n = 0;
    do_reset();
    req_in = 32'h8000_0001; code_ready = 1'b1;
    step();
    req_in = '0;
    for (int c = 0; c < 12; c++) begin
      if (rr_valid && got_n < 2) begin
        codes[got_n] = int'(rr_code); times[got_n] = c; got_n++;
      end
      step();
    end
    n_chk++;
    if (got_n != 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d codes want 2", got_n);
    end else begin
      n_chk++;
      if (codes[0] != 0 || codes[1] != 31 || times[1] - times[0] > 4) begin
        n_fail++; $display("FAIL wrap_order: got %0d,%0d gap %0d want 0,31 gap<=4",
                           codes[0], codes[1], times[1] - times[0]);
      end
    end
    // Pointer back at 0: lane 1 must beat lane 31.
    code_ready = 1'b0; req_in = 32'h8000_0002;
    step();
    req_in = '0;
    step();
    n_chk++;
    if ({rr_valid, rr_code} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL wrap_ptr0: got v=%b c=%0d want v=1 c=1", rr_valid, rr_code);
    end
    n_chk++;
    if (got_all !== {exp_of(0), exp_of(1)}) begin
      n_fail++; $display("FAIL wrap_model: got %h want %h", got_all, {exp_of(0), exp_of(1)});
    end
  endtask

  task automatic test_hold();
    do_reset();
    code_ready = 1'b0; req_in = 32'h20;
    step();
    for (int c = 0; c < 10; c++) begin
      req_in = (c == 3) ? 32'h8 : 32'h0;
      step();
      n_chk++;
      if ({rr_valid, rr_code} !== {1'b1, 5'd5}) begin
        n_fail++; $display("FAIL hold_stable: cycle %0d got v=%b c=%0d want v=1 c=5", c, rr_valid, rr_code);
      end
    end
    n_chk++;
    if ({rr_pend, rr_cnt} !== {32'h28, 6'd2}) begin
      n_fail++; $display("FAIL hold_count: got p=%h n=%0d want p=28 n=2", rr_pend, rr_cnt);
    end
    code_ready = 1'b1;
    step();
    n_chk++;
    if ({rr_valid, rr_pend} !== {1'b0, 32'h8}) begin
      n_fail++; $display("FAIL hold_accept: got v=%b p=%h want v=0 p=8", rr_valid, rr_pend);
    end
    step();
    n_chk++;
    if ({rr_valid, rr_code} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL hold_wrapsearch: got v=%b c=%0d want v=1 c=3", rr_valid, rr_code);
    end
    step();
    code_ready = 1'b0;
    n_chk++;
    if (got_all !== {exp_of(0), exp_of(1)}) begin
      n_fail++; $display("FAIL hold_model: got %h want %h", got_all, {exp_of(0), exp_of(1)});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_in = 32'h80; code_ready = 1'b0;
    step();
    req_in = '0;
    step();
    code_ready = 1'b1; req_in = 32'h80;
    step();
    code_ready = 1'b0; req_in = '0;
    n_chk++;
    if ({rr_valid, rr_pend[7]} !== 2'b01) begin
      n_fail++; $display("FAIL reaccept_sticky: got v=%b p7=%b want v=0 p7=1", rr_valid, rr_pend[7]);
    end
    step();
    n_chk++;
    if ({rr_valid, rr_code} !== {1'b1, 5'd7}) begin
      n_fail++; $display("FAIL reaccept_reoffer: got v=%b c=%0d want v=1 c=7", rr_valid, rr_code);
    end
    code_ready = 1'b1;
    step();
    code_ready = 1'b0;
    n_chk++;
    if (got_all !== {exp_of(0), exp_of(1)}) begin
      n_fail++; $display("FAIL reaccept_model: got %h want %h", got_all, {exp_of(0), exp_of(1)});
    end
  endtask

  task automatic test_clear();
    do_reset();
    req_in = 32'h0001_0125; code_ready = 1'b0;
    step();
    req_in = '0;
    step();
    n_chk++;
    if ({rr_valid, rr_cnt} !== {1'b1, 6'd5}) begin
      n_fail++; $display("FAIL clear_setup: got v=%b n=%0d want v=1 n=5", rr_valid, rr_cnt);
    end
    clr_all = 1'b1; req_in = 32'h0000_0800;
    step();
    clr_all = 1'b0; req_in = '0;
    n_chk++;
    if ({rr_valid, rr_pend, rr_cnt} !== {1'b0, 32'h0, 6'd0}) begin
      n_fail++; $display("FAIL clear_flush: got v=%b p=%h n=%0d want 0/0/0", rr_valid, rr_pend, rr_cnt);
    end
    step();
    n_chk++;
    if ({rr_valid, rr_pend} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL clear_drop: got v=%b p=%h want v=0 p=0", rr_valid, rr_pend);
    end
    n_chk++;
    if (got_all !== {exp_of(0), exp_of(1)}) begin
      n_fail++; $display("FAIL clear_model: got %h want %h", got_all, {exp_of(0), exp_of(1)});
    end
  endtask

  task automatic test_reset_hold_fixed();
    int k = 0;
    do_reset();
    req_in = 32'hFFFF_FFFF; code_ready = 1'b0;
    step();
    req_in = '0;
    step();
    n_chk++;
    if ({rr_valid, rr_cnt} !== {1'b1, 6'd32}) begin
      n_fail++; $display("FAIL full_count: got v=%b n=%0d want v=1 n=32", rr_valid, rr_cnt);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_chk++;
    if (got_all !== 88'd0) begin
      n_fail++; $display("FAIL reset_in_hold: got %h want 0", got_all);
    end
    req_in = 32'hFFFF_FFFF; code_ready = 1'b1;
    step();
    req_in = '0;
    for (int c = 0; c < 80 && k < 32; c++) begin
      if (fp_valid) begin
        n_chk++;
        if (fp_code !== 5'(k)) begin
          n_fail++; $display("FAIL fixed_order: code #%0d got %0d want %0d", k, fp_code, k);
        end
        k++;
      end
      step();
    end
    n_chk++;
    if (k != 32) begin
      n_fail++; $display("FAIL fixed_timeout: got %0d codes want 32", k);
    end
    code_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      clr_all    = ($urandom_range(0, 49) == 0);
      code_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) req_in = 32'hFFFF_FFFF;
      else if ($urandom_range(0, 3) == 0) req_in = $urandom & $urandom & $urandom;
      else req_in = '0;
      step();
      n_chk++;
      if (got_all !== {exp_of(0), exp_of(1)}) begin
        n_fail++; $display("FAIL random_model: cycle %0d got %h want %h", c, got_all, {exp_of(0), exp_of(1)});
      end
    end
    rst_n = 1'b1; clr_all = 1'b0; code_ready = 1'b0; req_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_in = '0; clr_all = 1'b0; code_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_clear();
    test_reset_hold_fixed();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
